// File: rtl/shift_add_mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
// Optional feature macro: SHIFT_ADD_MUL_EARLY_EXIT_EN (used by shift_add_mul_seq).
package shift_add_mul_pkg;

  // Sequencer states; the encoding is fixed so that it is visible in waveforms.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Width of the iteration counter, which must be able to hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_mul_seq_add_unit.sv
// Shared adder datapath of the shift-and-add multiplier: WIDTH + WIDTH -> WIDTH+1 bits.
// The carry-out is kept so that no product bit is ever lost.
// Optional feature macro: SHIFT_ADD_MUL_EARLY_EXIT_EN (has no effect on this unit).
module add_unit
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   sum
);

  // Purely combinational zero-extended addition.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
  end

endmodule

// File: rtl/shift_add_mul_seq.sv
// Iterative unsigned multiplier: one multiplier bit per cycle through a single shared adder.
// P holds the accumulator in its upper half and the remaining multiplier bits in its lower half.
// Optional feature macro: SHIFT_ADD_MUL_EARLY_EXIT_EN. When it is defined, RUN ends as soon as
// the remaining multiplier bits are all zero, and P is realigned by the shifts that were skipped.
module shift_add_mul_seq
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_r;
  state_e               state_next_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mcand_next_s;
  logic [2*WIDTH-1:0]   p_r;
  logic [2*WIDTH-1:0]   p_next_s;
  logic [2*WIDTH-1:0]   p_shift_s;
  logic [2*WIDTH-1:0]   p_run_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_next_s;
  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH:0]       sum_s;
  logic                 run_done_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;

  add_unit #(.WIDTH(WIDTH)) u_add (
    .x   (p_r[2*WIDTH-1:WIDTH]),
    .y   (addend_s),
    .sum (sum_s)
  );

  // Add the multiplicand only when the current multiplier LSB is set, then shift right.
  always_comb begin
    addend_s  = p_r[0] ? mcand_r : {WIDTH{1'b0}};
    p_shift_s = {sum_s, p_r[WIDTH-1:1]};
  end

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0] rem_s;
  logic             rem_zero_s;

  // Stop early once no multiplier bits remain; the skipped iterations would only shift P right.
  always_comb begin
    rem_s      = CNT_LAST - cnt_r;
    rem_zero_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      rem_zero_s = rem_zero_s & ((i >= int'(rem_s)) | ~p_shift_s[i]);
    end
    run_done_s = rem_zero_s;
    p_run_s    = p_shift_s >> rem_s;
  end
`else
  // Fixed schedule: exactly WIDTH iterations in RUN.
  always_comb begin
    run_done_s = (cnt_r == CNT_LAST);
    p_run_s    = p_shift_s;
  end
`endif

  // Next-state and datapath-update logic of the sequencer.
  always_comb begin
    state_next_s = state_r;
    mcand_next_s = mcand_r;
    p_next_s     = p_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          mcand_next_s = a;
          p_next_s     = {{WIDTH{1'b0}}, b};
          cnt_next_s   = {CNT_W{1'b0}};
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        p_next_s   = p_run_s;
        cnt_next_s = cnt_r + CNT_ONE;
        if (run_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and handshake output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mcand_r     <= {WIDTH{1'b0}};
      p_r         <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      mcand_r     <= mcand_next_s;
      p_r         <= p_next_s;
      cnt_r       <= cnt_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s == RUN) || (state_next_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign product   = p_r;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Scoreboard bench for shift_add_mul_seq: the driver pushes expected products and latencies,
// an independent monitor pops and compares whenever a product is handed over.
// Optional feature macro: SHIFT_ADD_MUL_EARLY_EXIT_EN (changes the expected latency only).
module tb_shift_add_mul_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic           busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc;
    int             lat;
  } exp_t;
  exp_t sb[$];

  shift_add_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer readiness: either random or a fixed level chosen by the test sequence.
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference latency from acceptance cycle to the first out_valid cycle.
  function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    int hb = 0;
    for (int i = 0; i < W; i++) if (bv[i]) hb = i + 1;
    return 1 + ((hb < 1) ? 1 : hb);
`else
    return W + 1;
`endif
  endfunction

  task automatic wait_in_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout(name);
  endtask

  // Issue one operation; push its expectation unless push is cleared.
  task automatic op(input int av, input int bv, input bit push);
    @(posedge clk); #1;
    wait_in_ready("wait_in_ready");
    in_valid = 1'b1;
    a = W'(av);
    b = W'(bv);
    if (push) sb.push_back('{prod: (2*W)'(av * bv), acc: cyc, lat: exp_lat(W'(bv))});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  // Monitor: latency on out_valid rise, product on handover, IDLE right after handover.
  bit prev_ov = 1'b0;
  bit prev_hs = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hs) begin
        check("idle_after_handover_in_ready", 32'(in_ready), 32'd1);
        check("idle_after_handover_out_valid", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got product %0h with empty scoreboard", product);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          if (out_ready) begin
            check("product", 32'(product), 32'(sb[0].prod));
            void'(sb.pop_front());
          end
        end
      end
    end
    prev_ov = out_valid && !rst;
    prev_hs = out_valid && out_ready && !rst;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    // Directed corner products with an always-ready consumer.
    fixed_ready = 1'b1;
    op(15, 15, 1'b1);
    op(9, 0, 1'b1);
    op(0, 7, 1'b1);
    op(3, 1, 1'b1);
    op(3, 8, 1'b1);
    drain();

    // Backpressure: product held, in_ready low, busy high for 10 cycles.
    fixed_ready = 1'b0;
    op(6, 7, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) timeout("backpressure_wait");
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'h2A);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    fixed_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    op(5, 3, 1'b0);
    check("rst_run_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_in_ready", 32'(in_ready), 32'd1);
    check("rst_run_out_valid", 32'(out_valid), 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_product", 32'(product), 32'd0);

    // Reset wins over a simultaneous in_valid.
    in_valid = 1'b1; a = 4'd1; b = 4'd1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_in_ready", 32'(in_ready), 32'd1);
    check("rst_vs_valid_busy", 32'(busy), 32'd0);
    op(2, 3, 1'b1);
    drain();

    // Exhaustive sweep with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) op(i / 16, i % 16, 1'b1);
    // Random operands.
    for (int i = 0; i < 40; i++) op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
    drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
